code_entry: RTL and testbench
=============================

CODE_ENTRY -- requirements
Module: code_entry

Interface
REQ-001 SHALL have parameter DIGIT_W, default 3, bit width of one code digit (colour).
REQ-002 SHALL have parameter MAX_COLOR, default 5, largest legal digit value.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port take_code  input  1  level from the start-state FSM; high = a code setter has been chosen.
REQ-006 SHALL have port active_p  input  1  setter identity from the start-state FSM; 1 = player A, 0 = player B.
REQ-007 SHALL have port enterA  input  1  player A enter button, raw level, synchronous to clk.
REQ-008 SHALL have port enterB  input  1  player B enter button, raw level, synchronous to clk.
REQ-009 SHALL have port digit  input  DIGIT_W  digit value from the switches.
REQ-010 SHALL have port code  output  4*DIGIT_W  secret code; digit 0 in the MS field, digit 3 in the LS field.
REQ-011 SHALL have port digit_idx  output  2  number of digits stored so far, modulo 4.
REQ-012 SHALL have port code_valid  output  1  high once all 4 digits are stored.
REQ-013 SHALL have port guesser  output  1  guessing player; 1 = A, 0 = B; meaningful only while code_valid = 1.
REQ-014 SHALL have port err  output  1  one-cycle pulse for a rejected (out-of-range) digit.

Function
REQ-015 SHALL implement FSM states IDLE, ENTER, LOCKED.
REQ-016 SHALL register enterA and enterB each cycle; a press SHALL be the cycle with button = 1 and previous sample = 0.
REQ-017 IDLE: when take_code = 1, the FSM SHALL go to ENTER at the next edge, latch setter = active_p, and clear code and digit_idx to 0.
REQ-018 ENTER: only presses of the latched setter's button SHALL count; the other player's presses SHALL be ignored, including a simultaneous press.
REQ-019 ENTER: on a counted press with digit <= MAX_COLOR, the FSM SHALL write digit into field digit_idx of code and increment digit_idx at the same edge.
REQ-020 ENTER: on a counted press with digit > MAX_COLOR, the FSM SHALL leave code and digit_idx unchanged and assert err for exactly the following cycle.
REQ-021 ENTER: the 4th accepted digit SHALL move the FSM to LOCKED at the same edge; digit_idx SHALL wrap to 0, and code_valid SHALL be 1 from the next cycle.
REQ-022 ENTER: if take_code drops to 0, the FSM SHALL return to IDLE at the next edge and clear code and digit_idx; partial codes are discarded.
REQ-023 A button held high SHALL count as a single press; a new press requires a low sample first.
REQ-024 LOCKED: code_valid SHALL be 1, guesser SHALL be the inverse of the latched setter, and code SHALL be frozen.
REQ-025 LOCKED: all presses, digit changes, and take_code changes SHALL be ignored; only reset leaves LOCKED.
REQ-026 code_valid SHALL be 0 in IDLE and ENTER; err SHALL be 0 outside ENTER.
REQ-027 No path from inputs to outputs SHALL be combinational; all outputs SHALL be registered or decoded from registered state.

Reset
REQ-028 Asserting reset SHALL immediately force state = IDLE, code = 0, digit_idx = 0, code_valid = 0, guesser = 0, err = 0, setter = 0, and button-history registers = 0, regardless of current state.
REQ-029 Reset asserted mid-entry SHALL discard all stored digits; after release, the FSM SHALL re-enter ENTER only when take_code = 1.

Verification
REQ-030 take_code=1, active_p=1; press A with digit 1, 2, 3, 4 -> code=12'o1234, code_valid=1 the cycle after the 4th press, guesser=0.
REQ-031 Setter B; press A with digit=2, press B with digit=5 -> only 5 is stored, digit_idx=1.
REQ-032 Setter A; press A with digit=7 -> err pulses 1 cycle, digit_idx stays 0; then digit=0 -> accepted, digit_idx=1.
REQ-033 Hold enterA high for 10 cycles with digit=3 -> exactly one digit stored.
REQ-034 After 2 digits, drop take_code -> IDLE with code=0 and digit_idx=0; raise take_code again -> entry restarts from digit 0.
REQ-035 In LOCKED, press both buttons and change digit, then assert reset -> code is unchanged until reset, after which all outputs read 0.

Source files
------------

// File: rtl/code_entry.sv
// Secret-code entry for a two-player code-breaking game: the chosen setter
// presses their enter button to store four colour digits, then the code locks.
module code_entry #(
  parameter int DIGIT_W   = 3,
  parameter int MAX_COLOR = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 take_code,
  input  logic                 active_p,
  input  logic                 enterA,
  input  logic                 enterB,
  input  logic [DIGIT_W-1:0]   digit,
  output logic [4*DIGIT_W-1:0] code,
  output logic [1:0]           digit_idx,
  output logic                 code_valid,
  output logic                 guesser,
  output logic                 err,
  output logic [1:0]           state_dbg
);

  // state_dbg encoding: 0 = IDLE, 1 = ENTER, 2 = LOCKED
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [DIGIT_W:0] MAX_EXT = (DIGIT_W+1)'(MAX_COLOR);

  state_t                 state, state_n;
  logic                   setter, setter_n;
  logic [4*DIGIT_W-1:0]   code_n;
  logic [1:0]             idx_n;
  logic                   err_n;
  logic                   a_q, b_q;
  logic                   a_press, b_press, counted, digit_ok;

  // Rising-edge detect: a held button only counts on its first high sample.
  assign a_press  = enterA & ~a_q;
  assign b_press  = enterB & ~b_q;
  assign counted  = setter ? a_press : b_press;
  assign digit_ok = ({1'b0, digit} <= MAX_EXT);

  always_comb begin
    state_n  = state;
    setter_n = setter;
    code_n   = code;
    idx_n    = digit_idx;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (take_code) begin
          state_n  = ENTER;
          setter_n = active_p;
          code_n   = '0;
          idx_n    = 2'd0;
        end
      end
      ENTER: begin
        if (!take_code) begin
          state_n = IDLE;
          code_n  = '0;
          idx_n   = 2'd0;
        end else if (counted) begin
          if (digit_ok) begin
            // Digit 0 lands in the most significant field.
            for (int i = 0; i < 4; i++) begin
              if (digit_idx == 2'(i)) code_n[(3-i)*DIGIT_W +: DIGIT_W] = digit;
            end
            idx_n = digit_idx + 2'd1;
            if (digit_idx == 2'd3) state_n = LOCKED;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      LOCKED: begin
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      setter    <= 1'b0;
      code      <= '0;
      digit_idx <= 2'd0;
      err       <= 1'b0;
      a_q       <= 1'b0;
      b_q       <= 1'b0;
    end else begin
      state     <= state_n;
      setter    <= setter_n;
      code      <= code_n;
      digit_idx <= idx_n;
      err       <= err_n;
      a_q       <= enterA;
      b_q       <= enterB;
    end
  end

  assign code_valid = (state == LOCKED);
  assign guesser    = (state == LOCKED) & ~setter;
  assign state_dbg  = state;

endmodule

// File: tb/tb_code_entry.sv
// Directed bench for code_entry: each step queues the expected outputs and
// compares them after the clock edge that should produce them.
module tb_code_entry;

  localparam int DW = 3;
  localparam int EW = 2 + 4*DW + 2 + 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          take_code = 1'b0;
  logic          active_p = 1'b0;
  logic          enterA = 1'b0;
  logic          enterB = 1'b0;
  logic [DW-1:0] digit = '0;
  logic [4*DW-1:0] code;
  logic [1:0]    digit_idx;
  logic          code_valid;
  logic          guesser;
  logic          err;
  logic [1:0]    state_dbg;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_ENTER = 2'd1, S_LOCKED = 2'd2;

  code_entry #(.DIGIT_W(DW), .MAX_COLOR(5)) dut (
    .clk(clk), .reset(reset), .take_code(take_code), .active_p(active_p),
    .enterA(enterA), .enterB(enterB), .digit(digit), .code(code),
    .digit_idx(digit_idx), .code_valid(code_valid), .guesser(guesser),
    .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [1:0] st, input logic [4*DW-1:0] c,
                          input logic [1:0] idx, input logic v, input logic g,
                          input logic e);
    exp_q.push_back({st, c, idx, v, g, e});
  endtask

  task automatic compare_out(input string tag);
    logic [EW-1:0] exp_v, obs_v;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s observed=no_expectation expected=queued_entry", tag);
      return;
    end
    exp_v = exp_q.pop_front();
    obs_v = {state_dbg, code, digit_idx, code_valid, guesser, err};
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  // Drive buttons/digit, queue what the next edge must produce, then check.
  task automatic step(input string tag, input logic a, input logic b,
                      input logic [DW-1:0] d, input logic [1:0] st,
                      input logic [4*DW-1:0] c, input logic [1:0] idx,
                      input logic v, input logic g, input logic e);
    enterA = a;
    enterB = b;
    digit  = d;
    push_exp(st, c, idx, v, g, e);
    @(posedge clk);
    #2;
    compare_out(tag);
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    push_exp(S_IDLE, '0, 2'd0, 1'b0, 1'b0, 1'b0);
    compare_out(tag);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #12;
    push_exp(S_IDLE, '0, 2'd0, 1'b0, 1'b0, 1'b0);
    compare_out("reset_state");
    reset = 1'b0;

    // Setter A enters 1,2,3,4
    take_code = 1'b1; active_p = 1'b1;
    step("a_enter", 0, 0, 0, S_ENTER, '0, 2'd0, 0, 0, 0);
    step("a_d1", 1, 0, 1, S_ENTER, 12'o1000, 2'd1, 0, 0, 0);
    step("a_r1", 0, 0, 1, S_ENTER, 12'o1000, 2'd1, 0, 0, 0);
    step("a_d2", 1, 0, 2, S_ENTER, 12'o1200, 2'd2, 0, 0, 0);
    step("a_r2", 0, 0, 2, S_ENTER, 12'o1200, 2'd2, 0, 0, 0);
    step("a_d3", 1, 0, 3, S_ENTER, 12'o1230, 2'd3, 0, 0, 0);
    step("a_r3", 0, 0, 3, S_ENTER, 12'o1230, 2'd3, 0, 0, 0);
    step("a_d4_lock", 1, 0, 4, S_LOCKED, 12'o1234, 2'd0, 1, 0, 0);

    // Locked code ignores buttons, digits and take_code
    for (int i = 0; i < 4; i++) begin
      take_code = (i % 2 == 1);
      step("locked_hold", 1'(i % 2), 1'(i % 2), DW'($urandom_range(0, 7)),
           S_LOCKED, 12'o1234, 2'd0, 1, 0, 0);
    end
    async_reset("locked_reset");

    // Setter B: A presses ignored, simultaneous press counts only B
    take_code = 1'b1; active_p = 1'b0;
    step("b_enter", 0, 0, 0, S_ENTER, '0, 2'd0, 0, 0, 0);
    step("b_other_press", 1, 0, 2, S_ENTER, '0, 2'd0, 0, 0, 0);
    step("b_r0", 0, 0, 2, S_ENTER, '0, 2'd0, 0, 0, 0);
    step("b_d5", 0, 1, 5, S_ENTER, 12'o5000, 2'd1, 0, 0, 0);
    step("b_r1", 0, 0, 5, S_ENTER, 12'o5000, 2'd1, 0, 0, 0);
    step("b_both", 1, 1, 4, S_ENTER, 12'o5400, 2'd2, 0, 0, 0);
    step("b_r2", 0, 0, 4, S_ENTER, 12'o5400, 2'd2, 0, 0, 0);
    step("b_d1", 0, 1, 1, S_ENTER, 12'o5410, 2'd3, 0, 0, 0);
    step("b_r3", 0, 0, 1, S_ENTER, 12'o5410, 2'd3, 0, 0, 0);
    step("b_lock", 0, 1, 0, S_LOCKED, 12'o5410, 2'd0, 1, 1, 0);
    take_code = 1'b0;
    step("b_locked_drop", 0, 0, 0, S_LOCKED, 12'o5410, 2'd0, 1, 1, 0);
    async_reset("b_reset");

    // Partial code discarded when take_code drops
    take_code = 1'b1; active_p = 1'b1;
    step("p_enter", 0, 0, 0, S_ENTER, '0, 2'd0, 0, 0, 0);
    step("p_d1", 1, 0, 1, S_ENTER, 12'o1000, 2'd1, 0, 0, 0);
    step("p_r1", 0, 0, 1, S_ENTER, 12'o1000, 2'd1, 0, 0, 0);
    step("p_d2", 1, 0, 2, S_ENTER, 12'o1200, 2'd2, 0, 0, 0);
    step("p_r2", 0, 0, 2, S_ENTER, 12'o1200, 2'd2, 0, 0, 0);
    take_code = 1'b0;
    step("p_drop", 0, 0, 0, S_IDLE, '0, 2'd0, 0, 0, 0);
    take_code = 1'b1;
    step("p_reenter", 0, 0, 0, S_ENTER, '0, 2'd0, 0, 0, 0);

    // Out-of-range digit pulses err for one cycle
    step("e_bad7", 1, 0, 7, S_ENTER, '0, 2'd0, 0, 0, 1);
    step("e_clear", 0, 0, 7, S_ENTER, '0, 2'd0, 0, 0, 0);
    step("e_d0", 1, 0, 0, S_ENTER, '0, 2'd1, 0, 0, 0);
    step("e_r0", 0, 0, 0, S_ENTER, '0, 2'd1, 0, 0, 0);

    // Held button counts once
    for (int i = 0; i < 10; i++)
      step("hold_a", 1, 0, 3, S_ENTER, 12'o0300, 2'd2, 0, 0, 0);
    step("hold_rel", 0, 0, 3, S_ENTER, 12'o0300, 2'd2, 0, 0, 0);

    // MAX_COLOR accepted, MAX_COLOR+1 rejected
    step("max_ok", 1, 0, 5, S_ENTER, 12'o0350, 2'd3, 0, 0, 0);
    step("max_r", 0, 0, 5, S_ENTER, 12'o0350, 2'd3, 0, 0, 0);
    step("max_bad", 1, 0, 6, S_ENTER, 12'o0350, 2'd3, 0, 0, 1);
    step("max_r2", 0, 0, 6, S_ENTER, 12'o0350, 2'd3, 0, 0, 0);

    // Reset mid-entry; re-entry waits for take_code
    take_code = 1'b0;
    async_reset("mid_reset");
    step("post_reset_idle", 0, 0, 0, S_IDLE, '0, 2'd0, 0, 0, 0);
    take_code = 1'b1;
    step("post_reset_enter", 0, 0, 0, S_ENTER, '0, 2'd0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
